// File: rtl/seg7_scan_display_pkg.sv
// Shared constants for the six-digit multiplexed 7-segment clock display.
// Patterns are active-low, bit order [6:0] = g..a.
package seg7_scan_display_pkg;

  localparam int NUM_DIGITS = 6;

  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [6:0] SEG_PAT [16] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000,  // 9
    SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH
  };

endpackage

// File: rtl/bcd_to_seg7.sv
// BCD nibble to active-low 7-segment pattern; non-decimal codes show a dash.
module bcd_to_seg7
  import seg7_scan_display_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg7
);

  assign seg7 = SEG_PAT[bcd];

endmodule

// File: rtl/seg7_scan_display.sv
// Six-digit hh:mm:ss scanner with ghost blanking, per-pair blinking and
// colon-style decimal points on digits 2 and 4.
module seg7_scan_display
  import seg7_scan_display_pkg::*;
#(
  parameter int SCAN_DIV  = 50000,
  parameter int BLINK_DIV = 25000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] time_data,
  input  logic        flash_hour,
  input  logic        flash_minute,
  input  logic        flash_second,
  output logic [7:0]  seg,
  output logic [5:0]  dig
);

  localparam int SCAN_W  = (SCAN_DIV  > 2) ? $clog2(SCAN_DIV)  : 1;
  localparam int BLINK_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
  localparam logic [2:0]         IDX_LAST   = 3'(NUM_DIGITS - 1);

  logic [SCAN_W-1:0]  scan_cnt;
  logic [2:0]         idx;
  logic [23:0]        frame;
  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_on;
  logic [2:0]         flash_now;
  logic [2:0]         flash_prev;
  logic               scan_wrap;
  logic               frame_wrap;
  logic [3:0]         nibble;
  logic [6:0]         seg7_dec;
  logic               pair_flag;
  logic               dp_on;
  logic [7:0]         seg_next;
  logic [5:0]         dig_next;

  assign flash_now  = {flash_hour, flash_minute, flash_second};
  assign scan_wrap  = (scan_cnt == SCAN_LAST);
  assign frame_wrap = scan_wrap && (idx == IDX_LAST);

  // Frame only reloads at the 5->0 wrap so a scan never mixes two times.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_cnt <= '0;
      idx      <= '0;
      frame    <= '0;
    end else begin
      if (scan_wrap) begin
        scan_cnt <= '0;
        idx      <= (idx == IDX_LAST) ? 3'd0 : idx + 3'd1;
      end else begin
        scan_cnt <= scan_cnt + SCAN_W'(1);
      end
      if (frame_wrap)
        frame <= time_data;
    end
  end

  // A flash request edge restarts the blink phase visible, overriding a wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blink_cnt  <= '0;
      blink_on   <= 1'b1;
      flash_prev <= '0;
    end else begin
      flash_prev <= flash_now;
      if (flash_now != flash_prev) begin
        blink_cnt <= '0;
        blink_on  <= 1'b1;
      end else if (blink_cnt == BLINK_LAST) begin
        blink_cnt <= '0;
        blink_on  <= ~blink_on;
      end else begin
        blink_cnt <= blink_cnt + BLINK_W'(1);
      end
    end
  end

  assign nibble = frame[{idx, 2'b00} +: 4];

  bcd_to_seg7 u_dec (
    .bcd  (nibble),
    .seg7 (seg7_dec)
  );

  always_comb begin
    pair_flag = flash_hour;
    case (idx)
      3'd0, 3'd1: pair_flag = flash_second;
      3'd2, 3'd3: pair_flag = flash_minute;
      default:    pair_flag = flash_hour;
    endcase
  end

  assign dp_on = blink_on && (flash_now == 3'b000) && ((idx == 3'd2) || (idx == 3'd4));

  always_comb begin
    seg_next = {~dp_on, seg7_dec};
    if (pair_flag && !blink_on)
      seg_next[6:0] = SEG_BLANK;
    dig_next = (scan_cnt == '0) ? 6'h3F : ~(6'd1 << idx);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg <= 8'hFF;
      dig <= 6'h3F;
    end else begin
      seg <= seg_next;
      dig <= dig_next;
    end
  end

endmodule

// File: tb/tb_seg7_scan_display.sv
// Self-checking bench for seg7_scan_display with SCAN_DIV=4, BLINK_DIV=40,
// using an elapsed-cycle arithmetic reference model.
module tb_seg7_scan_display;

  localparam int SD = 4;
  localparam int BD = 40;
  localparam int FRAME = SD * 6;

  logic        clk;
  logic        rst;
  logic [23:0] time_data;
  logic        flash_hour, flash_minute, flash_second;
  logic [7:0]  seg;
  logic [5:0]  dig;

  int tests = 0;
  int fails = 0;

  // model: edges since release, edge of last flash change, flags seen, frame
  int          e;
  int          c;
  logic [2:0]  prev_fl;
  logic [23:0] mframe;

  seg7_scan_display #(.SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
    .clk          (clk),
    .rst          (rst),
    .time_data    (time_data),
    .flash_hour   (flash_hour),
    .flash_minute (flash_minute),
    .flash_second (flash_second),
    .seg          (seg),
    .dig          (dig)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [23:0]     td;
    logic [5:0][6:0] exp;
  } vec_t;

  function automatic logic [6:0] ref_pat(input logic [3:0] n);
    logic [6:0] on_segs;
    case (n)
      4'd0: on_segs = 7'h3F;
      4'd1: on_segs = 7'h06;
      4'd2: on_segs = 7'h5B;
      4'd3: on_segs = 7'h4F;
      4'd4: on_segs = 7'h66;
      4'd5: on_segs = 7'h6D;
      4'd6: on_segs = 7'h7D;
      4'd7: on_segs = 7'h07;
      4'd8: on_segs = 7'h7F;
      4'd9: on_segs = 7'h6F;
      default: on_segs = 7'h40;
    endcase
    return ~on_segs;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic int active_digit();
    for (int k = 0; k < 6; k++)
      if (dig == ~(6'd1 << k)) return k;
    return -1;
  endfunction

  function automatic logic model_on(input int edges);
    return (((edges - c) / BD) % 2) == 0;
  endfunction

  task automatic model_reset();
    e = 0;
    c = 0;
    prev_fl = 3'b000;
    mframe = 24'h0;
  endtask

  // One clock: predict from current model + inputs, clock, advance model, compare.
  task automatic step();
    int idx, cnt;
    logic on;
    logic [2:0] fl;
    logic [7:0] es;
    logic [5:0] ed;
    fl  = {flash_hour, flash_minute, flash_second};
    cnt = e % SD;
    idx = (e / SD) % 6;
    on  = model_on(e);
    es[6:0] = (fl[idx/2] && !on) ? 7'h7F : ref_pat(mframe[4*idx +: 4]);
    es[7]   = !(on && fl == 3'b000 && (idx == 2 || idx == 4));
    ed      = (cnt == 0) ? 6'h3F : ~(6'd1 << idx);
    @(posedge clk);
    e++;
    if (fl != prev_fl) c = e;
    prev_fl = fl;
    if (e % FRAME == 0) mframe = time_data;
    @(negedge clk);
    check("dig", 32'(dig), 32'(ed));
    if (ed != 6'h3F) check("seg", 32'(seg), 32'(es));
  endtask

  initial begin
    vec_t vecs [4];
    bit   seen [6];
    int   k, n, blank1, blank2;

    vecs[0] = '{td: 24'h123456, exp: {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02}};
    vecs[1] = '{td: 24'h09A870, exp: {7'h40, 7'h10, 7'h3F, 7'h00, 7'h78, 7'h40}};
    vecs[2] = '{td: 24'hFEDCBA, exp: {7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F}};
    vecs[3] = '{td: 24'h235959, exp: {7'h24, 7'h30, 7'h12, 7'h10, 7'h12, 7'h10}};

    rst = 1'b0;
    time_data = 24'h123456;
    {flash_hour, flash_minute, flash_second} = 3'b000;
    repeat (3) @(negedge clk);
    check("reset_seg", 32'(seg), 32'hFF);
    check("reset_dig", 32'(dig), 32'h3F);
    rst = 1'b1;
    model_reset();

    // first frame after release shows zeros
    for (int s = 0; s < FRAME; s++) begin
      step();
      k = active_digit();
      if (k >= 0 && s < FRAME - 1) check("first_frame_zero", 32'(seg[6:0]), 32'h40);
    end

    // table-driven decode vectors
    for (int v = 0; v < 4; v++) begin
      time_data = vecs[v].td;
      for (int j = 0; j < 6; j++) seen[j] = 0;
      for (int s = 0; s < 2 * FRAME; s++) begin
        step();
        k = active_digit();
        if (s >= FRAME && k >= 0 && !seen[k]) begin
          seen[k] = 1;
          check($sformatf("vec%0d_dig%0d", v, k), 32'(seg[6:0]), 32'(vecs[v].exp[k]));
        end
      end
      for (int j = 0; j < 6; j++)
        if (!seen[j]) check($sformatf("vec%0d_dig%0d_seen", v, j), 0, 1);
    end

    // change time mid-frame: current frame keeps the old value
    time_data = 24'h123456;
    repeat (2 * FRAME) step();
    n = 0;
    while (((e / SD) % 6) != 3 && n < 40) begin step(); n++; end
    check("reach_idx3", 32'(((e / SD) % 6) == 3), 1);
    time_data = 24'h235959;
    n = 0;
    while (active_digit() != 5 && n < 40) begin step(); n++; end
    check("old_frame_hold", 32'(seg[6:0]), 32'h79);
    repeat (FRAME) step();
    n = 0;
    while (active_digit() != 5 && n < 40) begin step(); n++; end
    check("new_frame_seen", 32'(seg[6:0]), 32'h24);

    // flash restart: raise hour while blink is in its off half
    flash_second = 1'b1;
    n = 0;
    while (model_on(e) && n < 200) begin step(); n++; end
    check("blink_off_reached", 32'(model_on(e)), 0);
    flash_hour = 1'b1;
    step();
    blank1 = 0;
    blank2 = 0;
    for (int s = 0; s < 2 * BD; s++) begin
      step();
      k = active_digit();
      if ((k == 4 || k == 5) && seg[6:0] == 7'h7F) begin
        if (s < BD) blank1++; else blank2++;
      end
    end
    check("hour_visible_after_restart", 32'(blank1), 0);
    check("hour_blanks_later", 32'(blank2 > 0), 1);
    {flash_hour, flash_minute, flash_second} = 3'b000;

    // randomized flash toggles and time values against the model
    for (int s = 0; s < 1500; s++) begin
      if ($urandom_range(0, 59) == 0) begin
        case ($urandom_range(0, 2))
          0: flash_second = ~flash_second;
          1: flash_minute = ~flash_minute;
          default: flash_hour = ~flash_hour;
        endcase
      end
      if ($urandom_range(0, 29) == 0) time_data = 24'($urandom);
      step();
    end
    {flash_hour, flash_minute, flash_second} = 3'b000;
    repeat (100) step();

    // asynchronous reset in the middle of slot 3
    n = 0;
    while (!(((e / SD) % 6) == 3 && (e % SD) == 2) && n < 40) begin step(); n++; end
    #1 rst = 1'b0;
    #1;
    check("async_rst_seg", 32'(seg), 32'hFF);
    check("async_rst_dig", 32'(dig), 32'h3F);
    @(negedge clk);
    @(negedge clk);
    check("held_rst_dig", 32'(dig), 32'h3F);
    rst = 1'b1;
    model_reset();
    time_data = 24'h102030;
    step();
    check("restart_blank", 32'(dig), 32'h3F);
    step();
    check("restart_idx0", 32'(dig), 32'h3E);
    check("restart_zero", 32'(seg[6:0]), 32'h40);
    repeat (3 * FRAME) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seg7_scan_display.md
SEG7_SCAN_DISPLAY -- requirements
Module: seg7_scan_display

Interface
REQ-001 Parameter SCAN_DIV, default 50000, shall set the clk cycles per digit slot (min 2).
REQ-002 Parameter BLINK_DIV, default 25000000, shall set the clk cycles per blink half-period (min 2).
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 time_data  input  24  packed BCD hh:mm:ss: [23:20] hour tens … [3:0] second ones.
REQ-006 flash_hour, flash_minute, flash_second  input  1 each  blink request for the hour, minute or second digit pair.
REQ-007 seg  output  8  segment drive, active-low, [6:0]=g..a, [7]=dp.
REQ-008 dig  output  6  digit enable, active-low, dig[0]=second ones … dig[5]=hour tens.

Function
REQ-009 A scan counter shall count 0..SCAN_DIV-1 and wrap; at wrap, the digit index shall advance 0→1→…→5→0.
REQ-010 time_data shall be captured into a frame register only on the cycle the digit index wraps 5→0, so one frame never mixes two time values.
REQ-011 Nibble for digit k shall be frame[4k+3:4k]; values 0-9 decode to standard 7-segment patterns.
REQ-012 Nibble values 10-15 shall display a dash (segment g only lit).
REQ-013 In scan count 0 of every slot, dig shall be all ones (ghost blanking); in counts 1..SCAN_DIV-1, only dig[index] shall be 0.
REQ-014 seg and dig shall be registered: each takes the value for the current index/count one clk after that index/count state.
REQ-015 A blink counter shall count 0..BLINK_DIV-1 and toggle blink_on at wrap; blink_on=1 means visible.
REQ-016 When any flash input changes value, the blink counter shall clear to 0 and set blink_on=1 on the next cycle. This change takes precedence over a coincident wrap.
REQ-017 For a digit whose pair flag is 1 while blink_on=0, seg[6:0] shall be all ones (blank); dig still scans.
REQ-018 Pair mapping: digits 0-1 ← flash_second; 2-3 ← flash_minute; 4-5 ← flash_hour; multiple flags may be active at once.
REQ-019 dp (seg[7]) shall be lit (0) on digits 2 and 4 when blink_on=1 and all flash inputs are 0. Otherwise it shall be off (1).
REQ-020 Flash inputs shall be sampled every cycle (no frame latching).

Reset
REQ-021 While rst=0: seg=8'hFF, dig=6'h3F, scan count=0, index=0, blink count=0, blink_on=1, frame=0, flash history=0.
REQ-022 Reset mid-slot shall abort immediately. After release, the first slot shall be index 0, starting at count 0.
REQ-023 First frame capture after release shall occur at the first 5→0 wrap. Until then, digits display 0.

Structure
REQ-024 A shared package shall hold the NUM_DIGITS=6 constant, the sixteen 7-bit segment pattern constants, and the dash and blank patterns.
REQ-025 One combinational sub-module, bcd_to_seg7 (4-bit in, 7-bit active-low out), shall be instantiated once on the muxed nibble.

Verification (SCAN_DIV=4, BLINK_DIV=40)
REQ-026 rst low → seg=FF, dig=3F; release with time_data=24'h123456 → second frame shows digits 6,5,4,3,2,1 on dig[0..5], each low for 3 of every 4 cycles.
REQ-027 Change time_data to 24'h235959 at index 3 → the current frame still shows 123456; the change appears only after the next 5→0 wrap.
REQ-028 Nibble 4'hA on dig[0] → seg[6:0]=7'b0111111 (dash).
REQ-029 flash_minute=1 → digits 2-3 visible for 40 cycles, blank for 40 cycles, repeating; digits 0,1,4,5 steady; dp off.
REQ-030 Raise flash_hour while blink_on=0 → blink_on=1 and blink count=0 on the next cycle; hour digits visible for the following 40 cycles.
REQ-031 All flash=0 → dp lit on digits 2 and 4 in 40-cycle on/off alternation; rst pulse mid-slot index 3 → seg=FF/dig=3F within the same cycle; scan restarts at index 0.
